// File: rtl/word_unpacker_hl.sv
// Streams one N-bit word as two N/2-bit halves, high or low half first; zero-bubble between words.
// Optional words_done counter is present only when WORD_UNPACKER_HL_COUNT_EN is defined.
module word_unpacker_hl #(
    parameter int N = 16
) (
    input  logic           clk,
    input  logic           clear,
    input  logic [N-1:0]   in_word,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic           hi_first,
    output logic [N/2-1:0] out_half,
    output logic           out_valid,
    input  logic           out_ready,
    output logic           out_is_high,
    output logic           out_last
`ifdef WORD_UNPACKER_HL_COUNT_EN
    ,
    output logic [15:0]    words_done
`endif
);
    localparam int H = N / 2;

    typedef enum logic [1:0] {IDLE, FIRST, SECOND} state_t;

    state_t         state_q;
    logic [N-1:0]   buf_q;
    logic           ord_q;
    logic [H-1:0]   half_q;
    logic           valid_q;
    logic           is_high_q;
    logic           last_q;

    logic in_hs;
    logic out_hs;

    assign in_ready = (state_q == IDLE) || ((state_q == SECOND) && out_ready);
    assign in_hs    = in_valid && in_ready;
    assign out_hs   = valid_q && out_ready;

    // Outputs are registered alongside the state, so they are stable while stalled.
    always_ff @(posedge clk) begin
        if (clear) begin
            state_q   <= IDLE;
            buf_q     <= '0;
            ord_q     <= 1'b0;
            half_q    <= '0;
            valid_q   <= 1'b0;
            is_high_q <= 1'b0;
            last_q    <= 1'b0;
        end else begin
            case (state_q)
                FIRST: begin
                    if (out_hs) begin
                        state_q   <= SECOND;
                        half_q    <= ord_q ? buf_q[H-1:0] : buf_q[N-1:H];
                        is_high_q <= ~ord_q;
                        last_q    <= 1'b1;
                    end
                end
                IDLE, SECOND: begin
                    if (in_hs) begin
                        state_q   <= FIRST;
                        buf_q     <= in_word;
                        ord_q     <= hi_first;
                        half_q    <= hi_first ? in_word[N-1:H] : in_word[H-1:0];
                        valid_q   <= 1'b1;
                        is_high_q <= hi_first;
                        last_q    <= 1'b0;
                    end else if (state_q == SECOND && out_hs) begin
                        state_q   <= IDLE;
                        half_q    <= '0;
                        valid_q   <= 1'b0;
                        is_high_q <= 1'b0;
                        last_q    <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign out_half    = half_q;
    assign out_valid   = valid_q;
    assign out_is_high = is_high_q;
    assign out_last    = last_q;

`ifdef WORD_UNPACKER_HL_COUNT_EN
    logic [15:0] words_done_q;
    logic [15:0] words_done_d;

    assign words_done_d = (state_q == SECOND && out_hs) ? words_done_q + 16'd1 : words_done_q;

    always_ff @(posedge clk) begin
        if (clear) begin
            words_done_q <= '0;
        end else begin
            words_done_q <= words_done_d;
        end
    end

    assign words_done = words_done_q;
`endif

endmodule

// File: tb/tb_word_unpacker_hl.sv
// Scoreboard bench for word_unpacker_hl: stimulus pushes expected halves, a monitor pops on each output handshake.
module tb_word_unpacker_hl;
    logic        clk;
    logic        clear;
    logic [15:0] in_word;
    logic        in_valid;
    logic        in_ready;
    logic        hi_first;
    logic [7:0]  out_half;
    logic        out_valid;
    logic        out_ready;
    logic        out_is_high;
    logic        out_last;
`ifdef WORD_UNPACKER_HL_COUNT_EN
    logic [15:0] words_done;
`endif

    int nvec = 0;
    int nerr = 0;
    logic [9:0] sb[$];   // {half, is_high, last}

    word_unpacker_hl #(.N(16)) dut (
        .clk(clk),
        .clear(clear),
        .in_word(in_word),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .hi_first(hi_first),
        .out_half(out_half),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_is_high(out_is_high),
        .out_last(out_last)
`ifdef WORD_UNPACKER_HL_COUNT_EN
        ,
        .words_done(words_done)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    // Monitor: every output handshake (outside clear) must match the head of the scoreboard.
    initial begin
        logic [9:0] e;
        forever begin
            @(negedge clk);
            if (out_valid && out_ready && !clear) begin
                nvec++;
                if (sb.size() == 0) begin
                    nerr++;
                    $display("FAIL unexpected_output: got half %0h with no expected entry", out_half);
                end else begin
                    e = sb.pop_front();
                    if ({out_half, out_is_high, out_last} !== e) begin
                        nerr++;
                        $display("FAIL half_stream: got half %0h hi %0b last %0b expected half %0h hi %0b last %0b",
                                 out_half, out_is_high, out_last, e[9:2], e[1], e[0]);
                    end
                end
            end
        end
    end

    task automatic send(input logic [15:0] w, input logic hf, output int waits);
        in_word  = w;
        hi_first = hf;
        in_valid = 1'b1;
        waits    = 0;
        do begin
            @(negedge clk);
            waits++;
        end while (!in_ready && waits < 50);
        if (!in_ready) begin
            chk("accept_timeout", {31'd0, in_ready}, 32'd1);
        end else if (hf) begin
            sb.push_back({w[15:8], 1'b1, 1'b0});
            sb.push_back({w[7:0],  1'b0, 1'b1});
        end else begin
            sb.push_back({w[7:0],  1'b0, 1'b0});
            sb.push_back({w[15:8], 1'b1, 1'b1});
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    initial begin
        int w;
        clear     = 1'b1;
        in_word   = '0;
        in_valid  = 1'b0;
        hi_first  = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        clear = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_half", {24'd0, out_half}, 32'd0);
        chk("rst_is_high_last", {30'd0, out_is_high, out_last}, 32'd0);
`ifdef WORD_UNPACKER_HL_COUNT_EN
        chk("rst_words_done", {16'd0, words_done}, 32'd0);
`endif
        @(posedge clk);
        #1;

        // Single word, high first
        out_ready = 1'b1;
        send(16'hA55A, 1'b1, w);
        chk("idle_accept_wait", w, 32'd1);
        repeat (3) @(negedge clk);
        chk("idle_after_word_valid", {31'd0, out_valid}, 32'd0);
        chk("idle_after_word_half", {24'd0, out_half}, 32'd0);
        @(posedge clk);
        #1;

        // Low first
        send(16'h1234, 1'b0, w);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1;

        // Streaming: words 2 and 3 must be accepted on the second-half cycle
        send(16'h0102, 1'b1, w);
        chk("stream_w1_wait", w, 32'd1);
        send(16'h0304, 1'b1, w);
        chk("stream_w2_wait", w, 32'd2);
        send(16'h0506, 1'b1, w);
        chk("stream_w3_wait", w, 32'd2);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1;

        // Backpressure in FIRST with input noise
        out_ready = 1'b0;
        send(16'hC3D2, 1'b1, w);
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_word  = 16'(i * 16'h1111 + 16'h0F0F);
            hi_first = i[0];
            @(negedge clk);
            chk("bp_half_hold", {24'd0, out_half}, 32'h0000_00C3);
            chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1;

        // Clear while the second half is pending
        send(16'hBEEF, 1'b1, w);
        @(posedge clk);
        #1;
        clear    = 1'b1;
        in_valid = 1'b1;
        in_word  = 16'h7777;
        @(posedge clk);
        #1;
        clear    = 1'b0;
        in_valid = 1'b0;
        sb.delete();
        @(negedge clk);
        chk("clr_out_valid", {31'd0, out_valid}, 32'd0);
        chk("clr_in_ready", {31'd0, in_ready}, 32'd1);
`ifdef WORD_UNPACKER_HL_COUNT_EN
        chk("clr_words_done", {16'd0, words_done}, 32'd0);
`endif
        @(posedge clk);
        #1;

`ifdef WORD_UNPACKER_HL_COUNT_EN
        for (int i = 0; i < 5; i++) send(16'(16'h1000 + i), 1'b0, w);
        repeat (3) @(negedge clk);
        chk("words_done_count", {16'd0, words_done}, 32'd5);
        @(posedge clk);
        #1;
`endif

        for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
        chk("scoreboard_drained", sb.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
